// File: rtl/rtable_loader_if.sv
// Reward stream in and reward-table write port out, grouped for the loader.
// Handshake: a beat transfers on a rising clock edge where i_valid && o_ready are both high;
// the source holds i_data/i_last stable while i_valid is high and o_ready is low.
interface rtable_loader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
);
  logic                  i_valid;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_last;
  logic                  o_ready;
  logic                  o_wr_en;
  logic [ADDR_WIDTH-1:0] o_wr_addr;
  logic [DATA_WIDTH-1:0] o_wr_data;

  modport slave (
    input  i_valid, i_data, i_last,
    output o_ready, o_wr_en, o_wr_addr, o_wr_data
  );

  modport master (
    output i_valid, i_data, i_last,
    input  o_ready, o_wr_en, o_wr_addr, o_wr_data
  );
endinterface

// File: rtl/rtable_loader.sv
// Streams reward entries into the reward table, one write per cycle from a base address.
// Stops on i_last or at the last table entry; flags overflow or an out-of-range base in o_err.
module rtable_loader #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base_addr,
  rtable_loader_if.slave        bus,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_err,
  output logic [1:0]            o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  err_q, err_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic                  beat;

  assign beat = bus.i_valid && (state_q == LOAD);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    case (state_q)
      IDLE: begin
        if (i_start) begin
          ptr_d   = i_base_addr;
          count_d = '0;
          err_d   = 1'b0;
          if (i_base_addr > LAST_ADDR) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        if (beat) begin
          wr_en_d   = 1'b1;
          wr_addr_d = ptr_q;
          wr_data_d = bus.i_data;
          ptr_d     = ptr_q + ADDR_WIDTH'(1);
          count_d   = count_q + (ADDR_WIDTH+1)'(1);
          // i_last wins over overflow: a load that ends exactly at the top is clean.
          if (bus.i_last) begin
            state_d = DONE;
          end else if (ptr_q == LAST_ADDR) begin
            err_d   = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.o_ready   = (state_q == LOAD);
    bus.o_wr_en   = wr_en_q;
    bus.o_wr_addr = wr_addr_q;
    bus.o_wr_data = wr_data_q;
    o_busy        = (state_q == LOAD);
    o_done        = (state_q == DONE);
    o_count       = count_q;
    o_err         = err_q;
    o_state       = state_q;
  end

endmodule
